// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: multi-channel SPI ADC sequencer for MCP32xx-style parts.
// Walks the enabled channels of a latched mask, runs one cs_n frame per
// channel (start, SGL, address, null bit, DATA_W data bits) and emits each
// result as a tagged one-cycle o_valid pulse. Scans once or continuously.
//
// Optional build macro: SPI_ADC_SCANNER_THRESH_EN
//   When defined, adds input thresh and output above[NUM_CH-1:0]; each result
//   updates above[o_ch] <= (result >= thresh) in its o_valid cycle.
module spi_adc_scanner #(
    parameter int DATA_W  = 12,
    parameter int CH_W    = 3,
    parameter int CLK_DIV = 4,
    parameter bit SGL     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cont,
    input  logic [(1<<CH_W)-1:0]    ch_mask,
    input  logic                    miso,
    output logic                    sck,
    output logic                    mosi,
    output logic                    cs_n,
    output logic [DATA_W-1:0]       o_data,
    output logic [CH_W-1:0]         o_ch,
    output logic                    o_valid,
    output logic                    busy
`ifdef SPI_ADC_SCANNER_THRESH_EN
    ,
    input  logic [DATA_W-1:0]       thresh,
    output logic [(1<<CH_W)-1:0]    above
`endif
);

    localparam int NUM_CH     = 1 << CH_W;
    localparam int FRAME_BITS = 3 + CH_W + DATA_W;
    localparam int CNT_W      = $clog2(2 * CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    // Counter landmarks within a phase: end of a half bit, sck rise, end of a full bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SCK_RISE  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Returns {found, index} of the lowest set bit of m.
    function automatic logic [CH_W:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // Returns {found, index} of the lowest set bit of m strictly above cur.
    function automatic logic [CH_W:0] next_set(input logic [NUM_CH-1:0] m,
                                               input logic [CH_W-1:0]   cur);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // Command bit driven on mosi for frame bit idx: start '1', SGL, address
    // MSB first; the null bit and all data bits are 0.
    function automatic logic cmd_bit(input logic [BIT_W-1:0] idx,
                                     input logic [CH_W-1:0]  ch);
        logic b;
        b = 1'b0;
        if (idx == '0) begin
            b = 1'b1;
        end else if (idx == BIT_W'(1)) begin
            b = SGL;
        end else begin
            for (int j = 0; j < CH_W; j++) begin
                if (idx == BIT_W'(CH_W + 1 - j)) b = ch[j];
            end
        end
        return b;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;

    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                cs_n_q, cs_n_d;
    logic [DATA_W-1:0]   o_data_q, o_data_d;
    logic [CH_W-1:0]     o_ch_q, o_ch_d;
    logic                o_valid_q, o_valid_d;
    logic                busy_q, busy_d;

    logic [CH_W:0]       low_sel;
    logic [CH_W:0]       nxt_sel;

`ifdef SPI_ADC_SCANNER_THRESH_EN
    logic [NUM_CH-1:0]   above_q, above_d;
`endif

    // Sequencer next state: phase counters, channel walk and miso capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        shreg_d = shreg_q;
        low_sel = lowest_set(ch_mask);
        nxt_sel = next_set(mask_q, ch_q);

        case (state_q)
            S_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    mask_d  = ch_mask;
                    ch_d    = low_sel[CH_W-1:0];
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                // miso is taken on the same edge that raises sck. Every bit
                // is shifted in, so only the last DATA_W samples survive.
                if (cnt_q == HALF_LAST) shreg_d = {shreg_q[DATA_W-2:0], miso};
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) state_d = S_HOLD;
                    else                   bit_d   = bit_q + BIT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (nxt_sel[CH_W]) begin
                        state_d = S_SETUP;
                        ch_d    = nxt_sel[CH_W-1:0];
                    end else if (cont && (ch_mask != '0)) begin
                        state_d = S_SETUP;
                        mask_d  = ch_mask;
                        ch_d    = low_sel[CH_W-1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin and result outputs, decoded from the next state so they register glitch-free.
    always_comb begin
        cs_n_d    = ~((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
        sck_d     = (state_d == S_SHIFT) && (cnt_d >= SCK_RISE);
        mosi_d    = 1'b0;
        if (state_d == S_SETUP)      mosi_d = 1'b1;
        else if (state_d == S_SHIFT) mosi_d = cmd_bit(bit_d, ch_d);
        busy_d    = (state_d != S_IDLE);
        o_valid_d = (state_q == S_HOLD) && (state_d == S_GAP);
        o_data_d  = o_valid_d ? shreg_q : o_data_q;
        o_ch_d    = o_valid_d ? ch_q    : o_ch_q;
`ifdef SPI_ADC_SCANNER_THRESH_EN
        above_d   = above_q;
        if (o_valid_d) above_d[ch_q] = (shreg_q >= thresh);
`endif
    end

    // Control state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            o_data_q  <= '0;
            o_ch_q    <= '0;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SPI_ADC_SCANNER_THRESH_EN
            above_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            o_data_q  <= o_data_d;
            o_ch_q    <= o_ch_d;
            o_valid_q <= o_valid_d;
            busy_q    <= busy_d;
`ifdef SPI_ADC_SCANNER_THRESH_EN
            above_q   <= above_d;
`endif
        end
    end

    // Capture shift register; pure data, no reset needed.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign o_data  = o_data_q;
    assign o_ch    = o_ch_q;
    assign o_valid = o_valid_q;
    assign busy    = busy_q;
`ifdef SPI_ADC_SCANNER_THRESH_EN
    assign above   = above_q;
`endif

endmodule

// File: doc/spi_adc_scanner.md
Name: spi_adc_scanner

Overview:
- Parametrised multi-channel SPI ADC sequencer; successor to the fixed 12-bit single-channel SPI reader.
- Generates cs_n/sck/mosi framing for an MCP32xx-style ADC and captures DATA_W-bit results.
- Scans a programmable set of channels once or continuously.
- Delivers each result as a tagged one-cycle valid pulse to downstream display/indicator logic.

Parameters:
DATA_W, 12, ADC result width in bits (4..16)
CH_W, 3, channel address width; NUM_CH = 2**CH_W
CLK_DIV, 4, clk cycles per SCK half-period (>=2)
SGL, 1, value driven in the single-ended/differential command bit

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
start  in  1  begin a scan; sampled only in IDLE
cont  in  1  1 = restart the scan after the last enabled channel; 0 = one pass
ch_mask  in  NUM_CH  channel enable mask; bit i enables channel i
miso  in  1  ADC serial data out
sck  out  1  SPI clock; idles low (mode 0)
mosi  out  1  command bits to ADC
cs_n  out  1  ADC chip select, active-low
o_data  out  DATA_W  last captured result; holds until the next valid
o_ch  out  CH_W  channel of o_data
o_valid  out  1  one-cycle pulse when o_data/o_ch update
busy  out  1  high from the cycle after start is accepted until return to IDLE

Behaviour:
- Reset values: sck=0, mosi=0, cs_n=1, o_data=0, o_ch=0, o_valid=0, busy=0. State = IDLE, channel pointer = 0.
- Frame: FRAME_BITS = 3 + CH_W + DATA_W. Bit order:
  - start bit '1', then SGL, then channel address MSB first.
  - One null bit: mosi=0, miso ignored.
  - DATA_W data bits, MSB first; mosi=0 during data.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP | IDLE).
- IDLE:
  - start=1 with ch_mask!=0: latch ch_mask, select the lowest set bit, go to SETUP next cycle.
  - start=1 with ch_mask==0: ignored; stay IDLE, busy stays 0.
- SETUP: cs_n=0, sck=0, mosi = first command bit. Lasts CLK_DIV cycles.
- SHIFT: each bit is 2*CLK_DIV cycles.
  - First half: sck=0; mosi updates on the first cycle of the half.
  - Second half: sck=1.
  - miso is registered on the clk edge where sck goes 0->1.
  - Only the last DATA_W sampled bits go to the shift register.
- HOLD: sck=0, cs_n=0 for CLK_DIV cycles.
- GAP:
  - cs_n=1 for 2*CLK_DIV cycles.
  - On the first GAP cycle: o_valid=1, o_data = captured value, o_ch = frame channel.
- Channel advance at end of GAP: next higher set bit of the latched mask.
  - If none remain and cont=1: re-latch ch_mask, wrap to its lowest set bit, go to SETUP.
  - If cont=1 but the re-latched mask is 0: go to IDLE.
  - If cont=0: go to IDLE.
- Timing: cs_n low exactly (FRAME_BITS*2+2)*CLK_DIV cycles per frame (152 at defaults). Frame-to-frame period = (FRAME_BITS*2+4)*CLK_DIV (160).
- Start-to-output latency: cs_n falls 1 cycle after start is sampled. First o_valid = 1 + 152 cycles after start.
- ch_mask changes mid-pass do not take effect until the next wrap or the next start.
- cont deasserted mid-frame: the current frame completes and its o_valid is delivered, then IDLE at the end of the pass.
- start while busy: ignored.
- reset mid-frame: on the next edge all outputs return to reset values, no o_valid is produced, state = IDLE.

Optional Feature:
- Macro: SPI_ADC_SCANNER_THRESH_EN.
- Defined:
  - Adds input thresh [DATA_W-1:0] and output above [NUM_CH-1:0] (reset 0).
  - On each o_valid cycle, above[o_ch] <= (captured data >= thresh). This registered flag updates in the same cycle o_valid is high.
  - Other bits of above hold their values.
- Undefined: thresh and above ports are absent; no comparator logic.

Test Plan:
- Single channel: ch_mask=8'h20, cont=0, start pulse; model returns 12'hA5C.
  - mosi shows 1,1,1,0,1 in bits 0-4.
  - One o_valid with o_data=12'hA5C, o_ch=5, 153 cycles after start.
  - busy then drops; cs_n stays high.
- Multi-channel scan: ch_mask=8'b1000_0101, cont=0; model returns 12'h100+ch.
  - o_valid three times, 160 cycles apart, o_ch sequence 0, 2, 7, data 0x100/0x102/0x107.
  - Then IDLE.
- Continuous with mask change: cont=1, ch_mask=8'h03; switch mask to 8'h04 during the channel-0 frame.
  - Channel 1 still sampled.
  - Channels after the wrap are 2, 2, ...
  - Deassert cont: the pass ends and the block goes IDLE.
- Boundaries: start with ch_mask=0 -> no cs_n activity, busy=0. Second start while busy -> no extra frame. DATA_W=16, CH_W=2 build -> 21-bit frame, value 16'hFFFF captured.
- Reset mid-SHIFT: assert reset at cycle 60 of a frame.
  - Next cycle cs_n=1, sck=0, busy=0; no o_valid.
  - A subsequent start works normally.
- THRESH_EN build: thresh=12'h800; samples 0x7FF then 0x800 on channel 3.
  - above[3] = 0 then 1.
  - Other bits unchanged.
